mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
//  Two-master arbiter for the single-port synchronous RAM. Master 0 is the CPU
//  controller/datapath (instruction fetch, LDR, STR); master 1 is the I/O/loader
//  port. Masters issue MNONE/MREAD/MWRITE commands. The block grants the RAM
//  round-robin, runs one access at a time, and returns read data and a done
//  pulse to the winner.
// PARAMETERS
//  AW  9   RAM address width
//  DW  16  RAM data width
// PORTS
//  clk        in   1   rising-edge clock
//  reset      in   1   synchronous, active-high reset
//  m0_cmd     in   2   master0 cmd: 00 MNONE, 01 MREAD, 11 MWRITE, 10 treated as MNONE
//  m0_addr    in   AW  master0 address
//  m0_wdata   in   DW  master0 write data
//  m0_ready   out  1   master0 access complete (1-cycle pulse)
//  m0_rdata   out  DW  master0 read data, valid when m0_ready on a read
//  m1_cmd/m1_addr/m1_wdata/m1_ready/m1_rdata   same as m0_*, for master1
//  ram_addr   out  AW  RAM address (registered)
//  ram_din    out  DW  RAM write data (registered)
//  ram_write  out  1   RAM write enable (registered)
//  ram_dout   in   DW  RAM read data, valid 1 cycle after ram_addr
//  gnt        out  1   index of current/last granted master
//  busy       out  1   high in any state other than IDLE
// BEHAVIOUR
//  - Request: mK_req = (mK_cmd==01)|(mK_cmd==11). A master holds cmd, addr and
//    wdata stable until it samples mK_ready=1, then drops to MNONE or issues a
//    new command on the following cycle.
//  - FSM states: IDLE, ACCESS, RDWAIT, RDATA.
//    IDLE: when any req is high, choose the winner, latch cmd, addr and wdata
//      into ram_addr/ram_din, set ram_write=(cmd==11), and go to ACCESS.
//      With no request, stay in IDLE.
//    ACCESS, write: ram_write=1 for this cycle only. Winner's ready=1. Next
//      state is IDLE and ram_write clears.
//    ACCESS, read: ram_write=0. Next state is RDWAIT.
//    RDWAIT: ram_dout is valid. Register it into the winner's rdata. Next state
//      is RDATA.
//    RDATA: winner's ready=1. Next state is IDLE.
//  - Latency, cmd first seen in IDLE at cycle 0:
//    write: ready at cycle 1.
//    read: ready and rdata at cycle 3.
//    Each access is followed by at least 1 IDLE cycle.
//  - Arbitration: round-robin. Pointer last = gnt of the most recent grant.
//    If only one master requests, that master wins.
//    If both request, the winner is ~last.
//    gnt and last update only on an IDLE->ACCESS transition.
//  - Inputs are captured in IDLE only. Changes to cmd, addr or wdata during
//    ACCESS, RDWAIT or RDATA are ignored. The loser's request stays pending and
//    is not lost.
//  - mK_ready is decoded from state and gnt. Only the winner's ready can be
//    high, and never both masters' in the same cycle.
//  - mK_rdata holds its last captured value and updates only for a read won by
//    master K. A write never changes rdata.
//  - Reset values: state=IDLE, ram_write=0, ram_addr=0, ram_din=0, m0/m1_rdata=0,
//    gnt=1 and last=1 (master0 wins the first contention), busy=0, ready=0.
//  - Reset mid-operation: the FSM returns to IDLE at the next edge and no ready
//    is issued. A write whose ram_write was high in the reset cycle still
//    commits at that edge. A pending read is discarded and rdata is unchanged.
//  - Address and data pass through with no arithmetic. There is no wrap
//    handling; the address is AW bits as supplied.
// TESTING
//  1 Reset, then m0 MWRITE addr=5 wdata=16'hBEEF
//    -> ram_write=1 with ram_addr=5 one cycle later; m0_ready pulses once.
//    Then m0 MREAD addr=5 -> m0_ready and m0_rdata=16'hBEEF at cycle 3.
//  2 m0 and m1 both MREAD on the same cycle after reset
//    -> m0 served first (gnt=0), then m1 (gnt=1). m1_ready comes 4 cycles
//    after m0_ready.
//  3 Both masters hold requests continuously for 8 accesses
//    -> grants alternate 0,1,0,1,... with no starvation. Ready pulses never
//    overlap.
//  4 m1 MWRITE addr=3 while m0 changes its addr during m1's ACCESS
//    -> the RAM sees only m1's write. m0 is served next with its address
//    sampled in IDLE.
//  5 Assert reset in the RDWAIT cycle of an m0 read
//    -> no m0_ready, m0_rdata unchanged, busy=0 and state=IDLE after the edge.
//    Cmd 2'b10 is presented -> no grant and ram_write stays 0.

Source files
------------

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Round-robin arbiter that shares one single-port synchronous
//               RAM between two masters. Master 0 is the CPU side (fetch,
//               LDR, STR); master 1 is the I/O / loader port. One access is
//               in flight at a time; the winner gets a one-cycle ready pulse
//               and, on reads, registered read data.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   AW          RAM address width
//   DW          RAM data width
// Ports
//   clk         rising-edge clock
//   reset       synchronous, active-high reset
//   m0_cmd      master0 command: 00 none, 01 read, 11 write, 10 = none
//   m0_addr     master0 address
//   m0_wdata    master0 write data
//   m0_ready    master0 access complete (1-cycle pulse)
//   m0_rdata    master0 read data, valid when m0_ready on a read
//   m1_*        same as m0_* for master1
//   ram_addr    RAM address (registered)
//   ram_din     RAM write data (registered)
//   ram_write   RAM write enable (registered)
//   ram_dout    RAM read data, valid one cycle after ram_addr
//   gnt         index of the current / most recently granted master
//   busy        high whenever the FSM is not idle
// ============================================================================
module mem_arbiter #(
    parameter int AW = 9,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          reset,

    input  logic [1:0]    m0_cmd,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_ready,
    output logic [DW-1:0] m0_rdata,

    input  logic [1:0]    m1_cmd,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_ready,
    output logic [DW-1:0] m1_rdata,

    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    output logic          ram_write,
    input  logic [DW-1:0] ram_dout,

    output logic          gnt,
    output logic          busy
);

    // ------------------------------------------------------------------
    // Command encodings
    // ------------------------------------------------------------------
    localparam logic [1:0] c_mread  = 2'b01;
    localparam logic [1:0] c_mwrite = 2'b11;

    // ------------------------------------------------------------------
    // FSM state encoding
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RDWAIT = 2'd2,
        S_RDATA  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [AW-1:0] r_ram_addr;
    logic [DW-1:0] r_ram_din;
    logic          r_ram_write;
    // r_gnt doubles as the round-robin "last" pointer: both only change on
    // an IDLE->ACCESS transition, so one flop carries both meanings.
    logic          r_gnt;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    logic [1:0][1:0]    w_cmd;
    logic [1:0][AW-1:0] w_addr;
    logic [1:0][DW-1:0] w_wdata;
    logic [1:0]         w_req;
    logic [1:0]         w_ready;
    logic               w_winner;
    logic [1:0]         w_sel_cmd;
    logic               w_grant;
    logic               w_capture;
    logic               w_done;

    assign w_cmd   = {m1_cmd,   m0_cmd};
    assign w_addr  = {m1_addr,  m0_addr};
    assign w_wdata = {m1_wdata, m0_wdata};

    // ------------------------------------------------------------------
    // Per-master request decode, ready decode and read-data register
    // ------------------------------------------------------------------
    for (genvar k = 0; k < 2; k++) begin : g_master
        logic [DW-1:0] r_rdata;

        // 2'b10 is deliberately not a request.
        assign w_req[k] = (w_cmd[k] == c_mread) || (w_cmd[k] == c_mwrite);

        // Ready is pure decode of state and grant, so only the granted
        // master can ever see it and the two pulses cannot coincide.
        assign w_ready[k] = w_done && (r_gnt == 1'(k));

        // Read data is only replaced by a read this master won; reset wins
        // over a capture, which discards a read interrupted in RDWAIT.
        always_ff @(posedge clk) begin
            if (reset) begin
                r_rdata <= '0;
            end else if (w_capture && (r_gnt == 1'(k))) begin
                r_rdata <= ram_dout;
            end
        end
    end

    // ------------------------------------------------------------------
    // Round-robin winner selection
    // With both masters requesting, the one not served last wins; with a
    // single requester it simply wins. Result is only used in IDLE.
    // ------------------------------------------------------------------
    always_comb begin
        w_winner = 1'b0;
        if (w_req == 2'b11) begin
            w_winner = ~r_gnt;
        end else begin
            w_winner = w_req[1];
        end
    end

    assign w_sel_cmd = w_cmd[w_winner];

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and control strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_capture   = 1'b0;
        w_done      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (|w_req) begin
                    w_grant     = 1'b1;
                    w_state_nxt = S_ACCESS;
                end
            end
            S_ACCESS: begin
                // r_ram_write is high exactly in the ACCESS cycle of a write,
                // so it identifies the access type without a separate flag.
                if (r_ram_write) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_RDWAIT;
                end
            end
            S_RDWAIT: begin
                w_capture   = 1'b1;
                w_state_nxt = S_RDATA;
            end
            S_RDATA: begin
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // RAM-side registers and grant pointer
    // Inputs are captured only on a grant, so anything a master does while
    // the FSM is busy has no effect until the next IDLE cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ram_addr  <= '0;
            r_ram_din   <= '0;
            r_ram_write <= 1'b0;
            r_gnt       <= 1'b1;
        end else begin
            // Write enable lives for the single ACCESS cycle following a
            // write grant and drops automatically afterwards.
            r_ram_write <= w_grant && (w_sel_cmd == c_mwrite);
            if (w_grant) begin
                r_ram_addr <= w_addr[w_winner];
                r_ram_din  <= w_wdata[w_winner];
                r_gnt      <= w_winner;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign ram_addr  = r_ram_addr;
    assign ram_din   = r_ram_din;
    assign ram_write = r_ram_write;
    assign gnt       = r_gnt;
    assign busy      = (r_state != S_IDLE);

    assign m0_ready  = w_ready[0];
    assign m1_ready  = w_ready[1];
    assign m0_rdata  = g_master[0].r_rdata;
    assign m1_rdata  = g_master[1].r_rdata;

endmodule
`default_nettype wire
